// File: rtl/tmr_seq_pkg.sv
// tmr_seq_pkg: shared constants and types for the tmr sequencer.
//  - SEQ_* : sequencer slave register offsets
//  - TMR_* : register offsets of the attached tmr (master side)
//  - tmr_cr_v / seq_cr_v : control register layouts
//  - tmr_seq_st_e : sequencer FSM states
package tmr_seq_pkg;

  localparam logic [4:0] SEQ_CR  = 5'h00;
  localparam logic [4:0] SEQ_SR  = 5'h04;
  localparam logic [4:0] SEQ_CNT = 5'h08;
  localparam logic [4:0] SEQ_WP  = 5'h0C;
  localparam logic [4:0] SEQ_TD  = 5'h10;
  localparam logic [4:0] SEQ_IR  = 5'h14;

  localparam logic [4:0] TMR_CR  = 5'h00;
  localparam logic [4:0] TMR_RE  = 5'h08;
  localparam logic [4:0] TMR_IR  = 5'h0C;

  // tmr control word, en in bit 0
  typedef struct packed {
    logic ex;
    logic ie;
    logic r;
    logic en;
  } tmr_cr_v;

  typedef struct packed {
    logic ie;
    logic loop;
    logic en;
  } seq_cr_v;

  typedef enum logic [2:0] {
    ST_IDLE, ST_STOP, ST_LDRE, ST_START, ST_WAIT, ST_ACK, ST_NEXT, ST_FIN
  } tmr_seq_st_e;

  function automatic logic reg_we(input logic we, input logic [4:0] addr,
                                  input logic [4:0] a);
    return we && (addr == a);
  endfunction

endpackage

// File: rtl/tmr_seq_fsm.sv
// tmr_seq_fsm: sequencer state machine. Owns the state and the table index,
// and drives the master port towards the attached tmr (one write per write state).
//  clk, rstn      clock, async active-low reset
//  i_en, i_loop   sequencer control bits
//  i_tmr_irq      irq from tmr (sampled only in WAIT)
//  i_tbl_q        table entry at o_idx
//  i_last         index of the last used entry
//  o_idx, o_busy  status
//  o_start        sequence starting (clears done)
//  o_done_set     normal completion (sets done)
//  o_fin          FIN state (clears en)
//  o_m_*          master port to tmr
module tmr_seq_fsm
  import tmr_seq_pkg::*;
#(
  parameter int tmr_w = 8,
  parameter int depth = 8,
  localparam int idx_w = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_loop,
  input  logic             i_tmr_irq,
  input  logic [tmr_w-1:0] i_tbl_q,
  input  logic [idx_w-1:0] i_last,
  output logic [idx_w-1:0] o_idx,
  output logic             o_busy,
  output logic             o_start,
  output logic             o_done_set,
  output logic             o_fin,
  output logic [4:0]       o_m_addr,
  output logic             o_m_we,
  output logic [31:0]      o_m_wd
);

  localparam tmr_cr_v CR_GO = '{ex: 1'b0, ie: 1'b1, r: 1'b1, en: 1'b1};

  tmr_seq_st_e      r_st, w_nxt;
  logic [idx_w-1:0] r_idx;
  logic             w_last;

  assign w_last     = (r_idx == i_last);
  assign o_idx      = r_idx;
  assign o_busy     = (r_st != ST_IDLE);
  assign o_start    = (r_st == ST_IDLE) && i_en;
  // en still set in FIN means normal completion; an abort already cleared it
  assign o_done_set = (r_st == ST_FIN) && i_en;
  assign o_fin      = (r_st == ST_FIN);

  always_comb begin
    w_nxt = r_st;
    case (r_st)
      ST_IDLE:  if (i_en) w_nxt = ST_STOP;
      ST_STOP:  w_nxt = ST_LDRE;
      ST_LDRE:  w_nxt = ST_START;
      ST_START: w_nxt = ST_WAIT;
      ST_WAIT:  if (i_tmr_irq) w_nxt = ST_ACK;
      ST_ACK:   w_nxt = ST_NEXT;
      ST_NEXT:  w_nxt = (w_last && !i_loop) ? ST_FIN : ST_STOP;
      ST_FIN:   w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
    // CPU cleared en mid-sequence: stop the tmr and leave without done
    if (!i_en && r_st != ST_IDLE && r_st != ST_FIN) w_nxt = ST_FIN;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_st  <= ST_IDLE;
      r_idx <= '0;
    end else begin
      r_st <= w_nxt;
      if (r_st == ST_IDLE && i_en) begin
        r_idx <= '0;
      end else if (r_st == ST_NEXT && i_en) begin
        // last entry: wrap when looping, otherwise hold for status readback
        if (!w_last)     r_idx <= r_idx + 1'b1;
        else if (i_loop) r_idx <= '0;
      end
    end
  end

  always_comb begin
    o_m_we   = 1'b0;
    o_m_addr = '0;
    o_m_wd   = '0;
    case (r_st)
      ST_STOP:  begin o_m_we = 1'b1; o_m_addr = TMR_CR; end
      ST_LDRE:  begin o_m_we = 1'b1; o_m_addr = TMR_RE; o_m_wd = 32'(i_tbl_q); end
      ST_START: begin o_m_we = 1'b1; o_m_addr = TMR_CR; o_m_wd = 32'(CR_GO); end
      ST_ACK:   begin o_m_we = 1'b1; o_m_addr = TMR_IR; end
      ST_FIN:   begin o_m_we = 1'b1; o_m_addr = TMR_CR; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/tmr_seq.sv
// tmr_seq: autonomous sequencer stepping a private tmr through a table of
// compare values. Slave register file lives here; tmr_seq_fsm drives the tmr.
//  clk, rstn          clock, async active-low reset
//  addr, we, wd, rd   slave bus (rd combinational on addr)
//  irq                done & ie
//  m_addr, m_we, m_wd master port to the attached tmr
//  tmr_irq            irq from the attached tmr
module tmr_seq
  import tmr_seq_pkg::*;
#(
  parameter int tmr_w = 8,
  parameter int depth = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq,
  output logic [4:0]  m_addr,
  output logic        m_we,
  output logic [31:0] m_wd,
  input  logic        tmr_irq
);

  localparam int         idx_w   = $clog2(depth);
  localparam logic [4:0] DEPTH_C = 5'(depth);

  seq_cr_v          r_cr;
  logic [4:0]       r_cnt;
  logic [idx_w-1:0] r_wp;
  logic             r_done;
  logic [tmr_w-1:0] r_tbl [depth];

  logic [idx_w-1:0] w_idx;
  logic             w_busy, w_start, w_done_set, w_fin;
  logic [4:0]       w_cnt_m1;
  logic [31:0]      w_sr;
  logic             w_unused;

  assign w_unused = ^{wd, w_cnt_m1};

  // CNT of 0 behaves as 1, anything above depth as depth
  always_comb begin
    if (r_cnt == 5'd0)         w_cnt_m1 = 5'd0;
    else if (r_cnt > DEPTH_C)  w_cnt_m1 = DEPTH_C - 5'd1;
    else                       w_cnt_m1 = r_cnt - 5'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cr   <= '0;
      r_cnt  <= '0;
      r_wp   <= '0;
      r_done <= 1'b0;
      for (int i = 0; i < depth; i++) r_tbl[i] <= '0;
    end else begin
      if (reg_we(we, addr, SEQ_CR)) begin
        r_cr.ie   <= wd[2];
        r_cr.loop <= wd[1];
        // while busy en can only be cleared (abort), never set
        r_cr.en   <= w_busy ? (r_cr.en & wd[0]) : wd[0];
      end
      if (w_fin) r_cr.en <= 1'b0;
      if (reg_we(we, addr, SEQ_CNT)) r_cnt <= wd[4:0];
      if (reg_we(we, addr, SEQ_WP))  r_wp  <= wd[idx_w-1:0];
      if (reg_we(we, addr, SEQ_TD)) begin
        r_tbl[r_wp] <= wd[tmr_w-1:0];
        r_wp        <= r_wp + 1'b1;
      end
      // completion beats a same-cycle SEQ_IR clear
      if (w_done_set)                                r_done <= 1'b1;
      else if (w_start || reg_we(we, addr, SEQ_IR))  r_done <= 1'b0;
    end
  end

  always_comb begin
    w_sr             = '0;
    w_sr[8 +: idx_w] = w_idx;
    w_sr[1]          = r_done;
    w_sr[0]          = w_busy;
  end

  always_comb begin
    case (addr)
      SEQ_CR:  rd = 32'(r_cr);
      SEQ_SR:  rd = w_sr;
      SEQ_CNT: rd = 32'(r_cnt);
      SEQ_WP:  rd = 32'(r_wp);
      SEQ_TD:  rd = 32'(r_tbl[r_wp]);
      default: rd = '0;
    endcase
  end

  assign irq = r_done & r_cr.ie;

  tmr_seq_fsm #(.tmr_w(tmr_w), .depth(depth)) u_fsm (
    .clk        (clk),
    .rstn       (rstn),
    .i_en       (r_cr.en),
    .i_loop     (r_cr.loop),
    .i_tmr_irq  (tmr_irq),
    .i_tbl_q    (r_tbl[w_idx]),
    .i_last     (w_cnt_m1[idx_w-1:0]),
    .o_idx      (w_idx),
    .o_busy     (w_busy),
    .o_start    (w_start),
    .o_done_set (w_done_set),
    .o_fin      (w_fin),
    .o_m_addr   (m_addr),
    .o_m_we     (m_we),
    .o_m_wd     (m_wd)
  );

endmodule
